// File: rtl/sample_pacer_fifo.sv
// Elastic sample buffer paced by the divider tick: one sample released per EN_CK_i,
// with prefill, underrun hold/zero, sticky underrun flag and fill-level readout.
module sample_pacer_fifo #(
  parameter int C_DAT_W      = 16,
  parameter int C_DEPTH_LOG2 = 4,
  parameter int C_PREFILL    = 8,
  parameter bit C_UNDER_HOLD = 1'b1
) (
  input  logic                    CK_i,
  input  logic                    XARST_i,
  input  tri0 logic               RST_i,
  input  logic                    EN_CK_i,
  input  logic [C_DAT_W-1:0]      DAT_i,
  input  logic                    DAT_VALID_i,
  output logic                    DAT_READY_o,
  output logic [C_DAT_W-1:0]      SMPL_o,
  output logic                    SMPL_STB_o,
  output logic [C_DEPTH_LOG2:0]   LEVEL_o,
  output logic                    RUN_o,
  output logic                    UNDERRUN_o,
  output logic [7:0]              UNDER_CTR_o
);
  localparam int DEPTH = 1 << C_DEPTH_LOG2;
  localparam int LW    = C_DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]           LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]           LVL_PRE  = LW'(C_PREFILL);
  localparam logic [LW-1:0]           LVL_ONE  = LW'(1);
  localparam logic [C_DEPTH_LOG2-1:0] PTR_ONE  = C_DEPTH_LOG2'(1);

  typedef enum logic {ST_FILL, ST_RUN} state_t;

  state_t                  state_q;
  logic                    starved_q;
  logic [C_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic [C_DAT_W-1:0]      mem [DEPTH];
  logic [C_DAT_W-1:0]      smpl_q, fill_smpl;
  logic                    stb_q, under_q;
  logic [7:0]              under_ctr_q;
  logic                    full, push, pop, under_tick;

  assign full        = (level_q == LVL_FULL);
  assign DAT_READY_o = ~full & ~RST_i;
  assign push        = DAT_VALID_i & DAT_READY_o;
  // Pop only sees the registered level, so a word pushed this cycle is never bypassed.
  assign pop         = EN_CK_i & (state_q == ST_RUN) & (level_q != '0);
  // Ticks while refilling after an underrun still emit no sample and count as starved.
  assign under_tick  = EN_CK_i & (((state_q == ST_RUN) & (level_q == '0)) |
                                  ((state_q == ST_FILL) & starved_q));
  assign fill_smpl   = C_UNDER_HOLD ? smpl_q : '0;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CK_i) begin
    if (push) mem[wr_ptr_q] <= DAT_i;
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state_q     <= ST_FILL;
      starved_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      smpl_q      <= '0;
      stb_q       <= 1'b0;
      under_q     <= 1'b0;
      under_ctr_q <= '0;
    end else if (RST_i) begin
      state_q     <= ST_FILL;
      starved_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      smpl_q      <= '0;
      stb_q       <= 1'b0;
      under_q     <= 1'b0;
      under_ctr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
      stb_q   <= EN_CK_i;
      if (pop)          smpl_q <= mem[rd_ptr_q];
      else if (EN_CK_i) smpl_q <= fill_smpl;
      if (under_tick) begin
        under_q <= 1'b1;
        if (under_ctr_q != 8'hFF) under_ctr_q <= under_ctr_q + 8'd1;
      end
      case (state_q)
        ST_FILL: if (level_q >= LVL_PRE) begin
          state_q   <= ST_RUN;
          starved_q <= 1'b0;
        end
        ST_RUN: if (EN_CK_i && level_q == '0) begin
          state_q   <= ST_FILL;
          starved_q <= 1'b1;
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign SMPL_o      = smpl_q;
  assign SMPL_STB_o  = stb_q;
  assign LEVEL_o     = level_q;
  assign RUN_o       = (state_q == ST_RUN);
  assign UNDERRUN_o  = under_q;
  assign UNDER_CTR_o = under_ctr_q;
endmodule

// File: tb/tb_sample_pacer_fifo.sv
// Directed bench for sample_pacer_fifo: prefill vector table plus hand-written
// full / underrun / simultaneous / mid-run clear / divider pacing sequences.
module tb_sample_pacer_fifo;
  logic        CK_i = 1'b0;
  logic        XARST_i, RST_i, EN_CK_i, DAT_VALID_i;
  logic [15:0] DAT_i;
  logic        DAT_READY_o, SMPL_STB_o, RUN_o, UNDERRUN_o;
  logic [15:0] SMPL_o;
  logic [4:0]  LEVEL_o;
  logic [7:0]  UNDER_CTR_o;

  int checks = 0;
  int errors = 0;

  sample_pacer_fifo #(.C_DAT_W(16), .C_DEPTH_LOG2(4), .C_PREFILL(8), .C_UNDER_HOLD(1'b1)) dut (
    .CK_i(CK_i), .XARST_i(XARST_i), .RST_i(RST_i), .EN_CK_i(EN_CK_i),
    .DAT_i(DAT_i), .DAT_VALID_i(DAT_VALID_i), .DAT_READY_o(DAT_READY_o),
    .SMPL_o(SMPL_o), .SMPL_STB_o(SMPL_STB_o), .LEVEL_o(LEVEL_o), .RUN_o(RUN_o),
    .UNDERRUN_o(UNDERRUN_o), .UNDER_CTR_o(UNDER_CTR_o)
  );

  always #5 CK_i = ~CK_i;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        t;
    logic [4:0]  lvl;
    logic        run;
    logic        stb;
    logic [15:0] smpl;
    logic        rdy;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic v, logic [15:0] d, logic t, logic [4:0] lvl,
                              logic run, logic stb, logic [15:0] smpl, logic rdy);
    vec_t r;
    r.v = v; r.d = d; r.t = t; r.lvl = lvl; r.run = run; r.stb = stb; r.smpl = smpl; r.rdy = rdy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, take the edge, sample 1 time unit later.
  task automatic cyc(input logic v, input logic [15:0] d, input logic t, input logic r);
    DAT_VALID_i = v; DAT_i = d; EN_CK_i = t; RST_i = r;
    @(posedge CK_i); #1;
  endtask

  initial begin
    int nstb, nzero, gaps, acc;
    logic started, rdy_b;
    logic [15:0] nxt, expv;

    // prefill: push 1..8 one per cycle, tick every 7 cycles
    vecs[0]  = mk(1, 16'h0001, 1, 5'd1, 0, 1, 16'h0000, 1);
    vecs[1]  = mk(1, 16'h0002, 0, 5'd2, 0, 0, 16'h0000, 1);
    vecs[2]  = mk(1, 16'h0003, 0, 5'd3, 0, 0, 16'h0000, 1);
    vecs[3]  = mk(1, 16'h0004, 0, 5'd4, 0, 0, 16'h0000, 1);
    vecs[4]  = mk(1, 16'h0005, 0, 5'd5, 0, 0, 16'h0000, 1);
    vecs[5]  = mk(1, 16'h0006, 0, 5'd6, 0, 0, 16'h0000, 1);
    vecs[6]  = mk(1, 16'h0007, 0, 5'd7, 0, 0, 16'h0000, 1);
    vecs[7]  = mk(1, 16'h0008, 1, 5'd8, 0, 1, 16'h0000, 1);
    vecs[8]  = mk(0, 16'h0000, 0, 5'd8, 1, 0, 16'h0000, 1);
    vecs[9]  = mk(0, 16'h0000, 0, 5'd8, 1, 0, 16'h0000, 1);
    vecs[10] = mk(0, 16'h0000, 0, 5'd8, 1, 0, 16'h0000, 1);
    vecs[11] = mk(0, 16'h0000, 0, 5'd8, 1, 0, 16'h0000, 1);
    vecs[12] = mk(0, 16'h0000, 0, 5'd8, 1, 0, 16'h0000, 1);
    vecs[13] = mk(0, 16'h0000, 0, 5'd8, 1, 0, 16'h0000, 1);
    vecs[14] = mk(0, 16'h0000, 1, 5'd7, 1, 1, 16'h0001, 1);
    vecs[15] = mk(0, 16'h0000, 0, 5'd7, 1, 0, 16'h0001, 1);
    vecs[16] = mk(0, 16'h0000, 0, 5'd7, 1, 0, 16'h0001, 1);
    vecs[17] = mk(0, 16'h0000, 0, 5'd7, 1, 0, 16'h0001, 1);
    vecs[18] = mk(0, 16'h0000, 0, 5'd7, 1, 0, 16'h0001, 1);
    vecs[19] = mk(0, 16'h0000, 0, 5'd7, 1, 0, 16'h0001, 1);
    vecs[20] = mk(0, 16'h0000, 0, 5'd7, 1, 0, 16'h0001, 1);
    vecs[21] = mk(0, 16'h0000, 1, 5'd6, 1, 1, 16'h0002, 1);

    XARST_i = 1'b0; RST_i = 1'b0; EN_CK_i = 1'b0; DAT_VALID_i = 1'b0; DAT_i = '0;
    repeat (2) @(posedge CK_i);
    #1;
    chk("rst.smpl",  32'(SMPL_o), 32'h0);
    chk("rst.stb",   32'(SMPL_STB_o), 32'h0);
    chk("rst.lvl",   32'(LEVEL_o), 32'h0);
    chk("rst.run",   32'(RUN_o), 32'h0);
    chk("rst.und",   32'(UNDERRUN_o), 32'h0);
    chk("rst.ctr",   32'(UNDER_CTR_o), 32'h0);
    chk("rst.rdy",   32'(DAT_READY_o), 32'h1);
    XARST_i = 1'b1;

    for (int i = 0; i < 22; i++) begin
      cyc(vecs[i].v, vecs[i].d, vecs[i].t, 1'b0);
      chk($sformatf("pre%0d.lvl", i),  32'(LEVEL_o),     32'(vecs[i].lvl));
      chk($sformatf("pre%0d.run", i),  32'(RUN_o),       32'(vecs[i].run));
      chk($sformatf("pre%0d.stb", i),  32'(SMPL_STB_o),  32'(vecs[i].stb));
      chk($sformatf("pre%0d.smpl", i), 32'(SMPL_o),      32'(vecs[i].smpl));
      chk($sformatf("pre%0d.rdy", i),  32'(DAT_READY_o), 32'(vecs[i].rdy));
    end

    // full: 16 pushes fill, 17th refused, a tick frees one slot
    cyc(0, 0, 0, 1);
    chk("full.clr.lvl", 32'(LEVEL_o), 32'h0);
    for (int i = 0; i < 16; i++) cyc(1, 16'h0100 + 16'(i), 0, 0);
    chk("full.lvl16", 32'(LEVEL_o), 32'd16);
    chk("full.rdy0",  32'(DAT_READY_o), 32'h0);
    cyc(1, 16'h0110, 0, 0);
    chk("full.17th.lvl", 32'(LEVEL_o), 32'd16);
    chk("full.run",      32'(RUN_o), 32'h1);
    cyc(1, 16'h0110, 1, 0);
    chk("full.pop.lvl",  32'(LEVEL_o), 32'd15);
    chk("full.pop.smpl", 32'(SMPL_o), 32'h0100);
    chk("full.pop.rdy",  32'(DAT_READY_o), 32'h1);

    // underrun hold: 8 samples then two repeats of the last one
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 16'h0200 + 16'(i), 0, 0);
    cyc(0, 0, 0, 0);
    chk("ur.run", 32'(RUN_o), 32'h1);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 1, 0);
      expv = (k < 8) ? 16'h0200 + 16'(k) : 16'h0207;
      chk($sformatf("ur.tick%0d.smpl", k), 32'(SMPL_o), 32'(expv));
    end
    chk("ur.und", 32'(UNDERRUN_o), 32'h1);
    chk("ur.ctr", 32'(UNDER_CTR_o), 32'd2);
    chk("ur.run0", 32'(RUN_o), 32'h0);
    chk("ur.lvl", 32'(LEVEL_o), 32'h0);

    // simultaneous push + tick at level 0 in RUN
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 16'h0300 + 16'(i), 0, 0);
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 0);
    chk("sim.pre.lvl", 32'(LEVEL_o), 32'h0);
    chk("sim.pre.run", 32'(RUN_o), 32'h1);
    chk("sim.pre.und", 32'(UNDERRUN_o), 32'h0);
    cyc(1, 16'hA5A5, 1, 0);
    chk("sim.und",  32'(UNDERRUN_o), 32'h1);
    chk("sim.ctr",  32'(UNDER_CTR_o), 32'd1);
    chk("sim.lvl",  32'(LEVEL_o), 32'd1);
    chk("sim.run",  32'(RUN_o), 32'h0);
    chk("sim.smpl", 32'(SMPL_o), 32'h0307);
    for (int i = 0; i < 7; i++) cyc(1, 16'h0400 + 16'(i), 0, 0);
    cyc(0, 0, 0, 0);
    chk("sim.refill.run", 32'(RUN_o), 32'h1);
    cyc(0, 0, 1, 0);
    chk("sim.first.smpl", 32'(SMPL_o), 32'hA5A5);
    chk("sim.first.lvl",  32'(LEVEL_o), 32'd7);

    // mid-run synchronous clear at level 10, with a push that must be dropped
    for (int i = 0; i < 3; i++) cyc(1, 16'h0500 + 16'(i), 0, 0);
    chk("mrst.pre.lvl", 32'(LEVEL_o), 32'd10);
    chk("mrst.pre.run", 32'(RUN_o), 32'h1);
    DAT_VALID_i = 1'b1; DAT_i = 16'hDEAD; EN_CK_i = 1'b1; RST_i = 1'b1;
    #1;
    chk("mrst.rdy0", 32'(DAT_READY_o), 32'h0);
    @(posedge CK_i); #1;
    chk("mrst.lvl",  32'(LEVEL_o), 32'h0);
    chk("mrst.run",  32'(RUN_o), 32'h0);
    chk("mrst.und",  32'(UNDERRUN_o), 32'h0);
    chk("mrst.smpl", 32'(SMPL_o), 32'h0);
    chk("mrst.ctr",  32'(UNDER_CTR_o), 32'h0);
    chk("mrst.stb",  32'(SMPL_STB_o), 32'h0);
    cyc(0, 0, 0, 0);
    chk("mrst.after.lvl", 32'(LEVEL_o), 32'h0);

    // pacing from a 3/7 fractional divider with an always-valid producer
    cyc(0, 0, 0, 1);
    nstb = 0; nzero = 0; gaps = 0; acc = 0; started = 1'b0; nxt = 16'h0001; expv = 16'h0001;
    for (int c = 0; c < 702; c++) begin
      acc += 3;
      EN_CK_i = 1'b0;
      if (c < 700 && acc >= 7) begin EN_CK_i = 1'b1; acc -= 7; end
      if (c >= 700) acc = 0;
      DAT_VALID_i = 1'b1; DAT_i = nxt; RST_i = 1'b0;
      #0 rdy_b = DAT_READY_o;
      @(posedge CK_i); #1;
      if (rdy_b) nxt = nxt + 16'd1;
      if (SMPL_STB_o) begin
        nstb++;
        if (!started && SMPL_o == 16'h0) nzero++;
        else begin
          started = 1'b1;
          if (SMPL_o != expv) gaps++;
          expv = expv + 16'd1;
        end
      end
    end
    DAT_VALID_i = 1'b0; EN_CK_i = 1'b0;
    chk("pace.nstb",   32'(nstb), 32'd300);
    chk("pace.nzero",  32'(nzero), 32'd3);
    chk("pace.gaps",   32'(gaps), 32'd0);
    chk("pace.popped", 32'(expv - 16'd1), 32'd297);
    chk("pace.ctr",    32'(UNDER_CTR_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sample_pacer_fifo.md
# sample_pacer_fifo

Elastic sample buffer that sits directly downstream of the fractional tick divider in the audio oscillator path. A producer writes samples through a valid/ready handshake. The divider's `EN_CK_o` tick drives `EN_CK_i` here, and on each tick the block releases exactly one sample, so output samples come out at the divider's average rate. It provides prefill, underrun detection and recovery, and a fill-level readout for rate trimming.

## Interface
- `C_DAT_W`, 16: sample width in bits.
- `C_DEPTH_LOG2`, 4: log2 of FIFO depth (depth = 16).
- `C_PREFILL`, 8: level required to leave FILL; legal range 1..depth.
- `C_UNDER_HOLD`, 1: on a tick with no sample, 1 = repeat last sample, 0 = output zero.
- `CK_i` in 1: single clock; all logic on posedge.
- `XARST_i` in 1: asynchronous active-low reset.
- `RST_i` in 1: synchronous clear, active high, tri0.
- `EN_CK_i` in 1: sample-rate tick from the divider; one release per cycle it is high.
- `DAT_i` in C_DAT_W: write data.
- `DAT_VALID_i` in 1: write request.
- `DAT_READY_o` out 1: `~full & ~RST_i`. Combinational from level.
- `SMPL_o` out C_DAT_W: registered output sample.
- `SMPL_STB_o` out 1: one-cycle pulse, the cycle after every tick.
- `LEVEL_o` out C_DEPTH_LOG2+1: current occupancy, 0..depth.
- `RUN_o` out 1: high in state RUN.
- `UNDERRUN_o` out 1: sticky flag, set on underrun, cleared only by reset or `RST_i`.
- `UNDER_CTR_o` out 8: saturating count of underrun ticks.

## Operation
- Storage is a circular buffer with a wr pointer and an rd pointer of C_DEPTH_LOG2 bits each, plus a level counter of C_DEPTH_LOG2+1 bits. Pointers wrap modulo depth.
- Push occurs when `DAT_VALID_i & DAT_READY_o`. `DAT_i` is written at the wr pointer, and the wr pointer increments.
- There is no fall-through: data pushed in cycle n is not poppable before cycle n+1.
- State FILL is entered at reset, at `RST_i`, and after an underrun.
  - In FILL, ticks do not pop.
  - `SMPL_o` is held (C_UNDER_HOLD=1) or forced to 0 (C_UNDER_HOLD=0).
  - `SMPL_STB_o` still pulses, so the output rate stays constant.
  - FILL→RUN at the edge where the registered level ≥ C_PREFILL.
- State RUN:
  - A tick with level>0 pops the head into `SMPL_o` and increments the rd pointer.
  - A tick with level==0 is an underrun:
    - `SMPL_o` follows the C_UNDER_HOLD rule.
    - `UNDERRUN_o` is set.
    - `UNDER_CTR_o` increments, saturating at 255.
    - The state returns to FILL.
- Push and pop in the same cycle: both happen and the level is unchanged.
- When full, `DAT_READY_o` is low even if a tick pops in that same cycle. `DAT_READY_o` rises the next cycle.
- Pop at level 0 with a simultaneous push is an underrun. The pushed word stays queued and the level becomes 1.
- `RST_i` has priority over everything. It clears the pointers, level, `SMPL_o`, `SMPL_STB_o`, `UNDERRUN_o` and `UNDER_CTR_o`, and sets state to FILL. Writes are refused while `RST_i` is high.

## Timing
- Reset values:
  - `SMPL_o`=0, `SMPL_STB_o`=0, `LEVEL_o`=0, `RUN_o`=0, `UNDERRUN_o`=0, `UNDER_CTR_o`=0.
  - `DAT_READY_o`=1 while `RST_i`=0.
- Tick latency: `EN_CK_i` high at edge k updates `SMPL_o` at edge k. `SMPL_STB_o` is high during cycle k..k+1, valid together with the new `SMPL_o`.
- `LEVEL_o` and `RUN_o` are registered and reflect all pushes and pops taken at the previous edge.
- Minimum push-to-output latency: push at edge n, state already RUN, FIFO empty before the push. `SMPL_o` can update at the tick edge n+1 at earliest.
- Back-to-back ticks on every cycle are legal. Sustained throughput is one sample per cycle when `DAT_VALID_i` is held high.
- Deassertion of `XARST_i` is synchronized externally; the block adds no synchronizer.

## Test plan
- Prefill: reset, push 0x0001..0x0008 with one tick every 7 cycles.
  - `RUN_o` rises the edge after the 8th push.
  - The first ticks before that produce `SMPL_STB_o` with `SMPL_O`=0.
  - The next ticks output 0x0001, 0x0002, … in order.
- Full: push 17 words with no ticks.
  - `LEVEL_o`=16 and `DAT_READY_o`=0 after the 16th push; the 17th word is not accepted.
  - A tick then lowers `LEVEL_o` to 15, and `DAT_READY_o`=1 the next cycle.
- Underrun hold: reach RUN with C_PREFILL=8, stop pushing, tick 10 times.
  - 8 samples come out, then ticks 9 and 10 repeat the 8th value.
  - `UNDERRUN_o`=1, `UNDER_CTR_o`=2, `RUN_o`=0.
- Simultaneous: in RUN at level 0, push 0xA5A5 in the same cycle as a tick.
  - Underrun is counted and `LEVEL_o`=1.
  - The next tick in RUN after refill to C_PREFILL outputs 0xA5A5 first.
- Pacing with the divider: feed `EN_CK_i` from a PERIOD=7 / PULSE_N=3 divider with the producer always valid.
  - Exactly 300 `SMPL_STB_o` pulses in 700 cycles.
  - The output sequence equals the input sequence with no gaps after prefill.
- Mid-run `RST_i`: at level 10 in RUN, assert `RST_i` for 1 cycle.
  - Next cycle: `LEVEL_o`=0, `RUN_o`=0, `UNDERRUN_o`=0, `SMPL_o`=0.
  - A push during the `RST_i` cycle is ignored.
